pattern_scan_ctrl: RTL
======================

# pattern_scan_ctrl

Round-robin scheduler that shares one serial "10010" overlapping Mealy detector among NREQ requesters. Each granted requester submits a WORD_W-bit word. The controller serializes the word MSB-first through the shared detector, one bit per cycle. It then returns a per-word match count and a match-position mask. The block sits between parallel word producers and the serial pattern-detection datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WORD_W, 8, bits per submitted word (4..32)
- ID_W, $clog2(NREQ), requester index width
- CNT_W, $clog2(WORD_W+1), match count width
- clk  in  1  clock; all logic is on its rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level
- req_data  in  NREQ*WORD_W  word for requester i, held in slice [i*WORD_W +: WORD_W]
- gnt  out  NREQ  one-hot, 1-cycle pulse; cycle in which req_data[i] is captured
- busy  out  1  high from the grant cycle through the done cycle
- done  out  1  1-cycle pulse; result outputs are valid
- done_id  out  ID_W  requester whose word produced the result
- match_cnt  out  CNT_W  number of pattern completions in the word
- match_mask  out  WORD_W  bit i set when the pattern completed on req_data bit i

## Operation
- Controller FSM states: IDLE, SCAN, DONE.
- IDLE, any req high:
  - Grant the first requester at or after rr_ptr (wrap modulo NREQ).
  - Pulse gnt for that requester, latch its word into the shift register, and load the detector state.
  - Clear the count and mask, then move to SCAN.
  - Set rr_ptr to grantee+1 (wraps).
- IDLE, no req: stay in IDLE.
- SCAN: lasts WORD_W cycles.
  - Each cycle, feed the shift-register MSB to the detector with valid=1, then shift left.
  - The bit-position counter runs WORD_W-1 down to 0.
  - On a detector match, increment the count and set mask[pos].
- Last SCAN cycle goes to DONE.
- DONE: assert done with the results, write back the detector context (see Configuration), then return to IDLE.
- Detector, 5 one-hot states S_R, S_1, S_10, S_100, S_1001, with overlap:
  - S_R: 1→S_1, 0→S_R.
  - S_1: 1→S_1, 0→S_10.
  - S_10: 1→S_1, 0→S_100.
  - S_100: 1→S_1001, 0→S_R.
  - S_1001: 1→S_1, 0→S_10 with match=1.
- Requesters must hold req_data stable while req is high until gnt. They must drop req in the cycle after gnt, or they re-enter arbitration.
- A req arriving during SCAN or DONE waits; it is arbitrated in the next IDLE cycle.
- match_cnt, match_mask and done_id hold their values until the next done.
- match_cnt never overflows, because CNT_W covers WORD_W.

## Timing
- Reset values: gnt=0, busy=0, done=0, done_id=0, match_cnt=0, match_mask=0, rr_ptr=0, state=IDLE, detector=S_R, all context entries S_R.
- Grant at cycle T, SCAN over T+1..T+WORD_W, done at T+WORD_W+1.
- Earliest next grant is T+WORD_W+2, giving throughput of 1 word per WORD_W+2 cycles.
- rst in any state (including mid-SCAN) aborts the scan with no done pulse. All outputs take their reset values in the next cycle, and the next grant starts priority from requester 0.
- busy is asserted combinationally with gnt in cycle T.

## Configuration
- PATSCAN_CONTEXT_EN defined:
  - Per-requester 5-bit detector context register.
  - At grant, the detector loads the grantee's context; at DONE, the final state is written back.
  - A pattern can therefore span consecutive words from the same requester.
- PATSCAN_CONTEXT_EN undefined:
  - No context storage.
  - The detector loads S_R at every grant, so patterns never span words.

## Structure
- Package patscan_pkg holds:
  - the one-hot detector state constants S_R..S_1001 (5-bit);
  - the controller state encoding IDLE/SCAN/DONE;
  - the pattern constant 5'b10010 (documentation only).
- Sub-module patscan_core: the serial detector.
  - Ports: clk, rst, load, load_state[4:0], valid, in, match, state[4:0].
  - match is the Mealy output for the current bit, combinational from state and in.

## Test plan
- WORD_W=8, req[0]=1 with data 8'b1001_0010 → gnt[0] at T; done at T+9 with done_id=0, match_cnt=2, match_mask=8'b0000_1001.
- req=4'b1111 held from reset (data 0) → grant order 0,1,2,3,0; grants spaced 10 cycles apart; all results match_cnt=0.
- req[1] word 8'b0000_1001, then req[1] word 8'h00:
  - with PATSCAN_CONTEXT_EN → second result match_cnt=1, match_mask=8'h80;
  - without it → match_cnt=0, match_mask=0.
- req[2] rises during SCAN of requester 0 → gnt[2] in the first IDLE cycle after done; no gnt pulse during SCAN or DONE.
- rst asserted in the 3rd SCAN cycle → no done pulse; busy=0 and all outputs zero the next cycle; with req=4'b1010 afterwards, requester 1 is granted first.
- Data 8'hFF and 8'h00 → match_cnt=0, match_mask=0; done still pulses exactly once per grant.

Source files
------------

// File: rtl/patscan_pkg.sv
// patscan_pkg: detector one-hot states, controller states and the detector transition function.
package patscan_pkg;
  localparam logic [4:0] S_R    = 5'b00001;
  localparam logic [4:0] S_1    = 5'b00010;
  localparam logic [4:0] S_10   = 5'b00100;
  localparam logic [4:0] S_100  = 5'b01000;
  localparam logic [4:0] S_1001 = 5'b10000;
  localparam logic [4:0] PATTERN = 5'b10010;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} ctrl_state_t;
  // Overlapping "10010": a completed match falls back to S_10 so its tail can start the next one.
  function automatic logic [4:0] det_next(input logic [4:0] s, input logic b);
    return (s == S_100) ? (b ? S_1001 : S_R) :
           b            ? S_1 :
           (s == S_1)   ? S_10 :
           (s == S_10)  ? S_100 :
           (s == S_1001) ? S_10 : S_R;
  endfunction
endpackage

// File: rtl/patscan_core.sv
// patscan_core: serial overlapping "10010" Mealy detector with a loadable one-hot state.
module patscan_core
  import patscan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] load_state,
  input  logic       valid,
  input  logic       in,
  output logic       match,
  output logic [4:0] state
);
  logic [4:0] r_state;
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_R;
    else if (load) r_state <= load_state;
    else if (valid) r_state <= det_next(r_state, in);
  end
  assign state = r_state;
  assign match = (r_state == S_1001) && !in;
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: round-robin sharing of one serial "10010" detector among NREQ word producers.
// PATSCAN_CONTEXT_EN keeps per-requester detector context so matches can span consecutive words.
module pattern_scan_ctrl
  import patscan_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int ID_W   = $clog2(NREQ),
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [WORD_W-1:0]      match_mask
);
  localparam int POS_W = $clog2(WORD_W);
  ctrl_state_t       r_state, w_nstate;
  logic [ID_W-1:0]   r_rr_ptr, r_id, r_done_id, w_gid;
  logic              w_found, w_start, w_match;
  logic [WORD_W-1:0] r_sh, r_mask, r_match_mask, w_mask_nxt;
  logic [CNT_W-1:0]  r_cnt, r_match_cnt, w_cnt_nxt;
  logic [POS_W-1:0]  r_pos;
  logic [4:0]        w_load_state, w_det_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_nstate;
  end

  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    for (int k = 0; k < NREQ; k++)
      if (!w_found && req[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gid   = ID_W'((int'(r_rr_ptr) + k) % NREQ);
      end
    w_start  = (r_state == IDLE) && w_found && !rst;
    w_nstate = (r_state == IDLE) ? (w_start ? SCAN : IDLE) :
               (r_state == SCAN) ? ((r_pos == '0) ? DONE : SCAN) : IDLE;
  end

  assign w_cnt_nxt  = r_cnt + CNT_W'(w_match);
  assign w_mask_nxt = r_mask | (w_match ? (WORD_W'(1) << r_pos) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_sh         <= '0;
      r_pos        <= '0;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_done_id    <= '0;
      r_match_cnt  <= '0;
      r_match_mask <= '0;
    end else if (w_start) begin
      r_rr_ptr <= (w_gid == ID_W'(NREQ - 1)) ? '0 : w_gid + 1'b1;
      r_id     <= w_gid;
      r_sh     <= req_data[int'(w_gid)*WORD_W +: WORD_W];
      r_pos    <= POS_W'(WORD_W - 1);
      r_cnt    <= '0;
      r_mask   <= '0;
    end else if (r_state == SCAN) begin
      r_sh   <= r_sh << 1;
      r_pos  <= r_pos - 1'b1;
      r_cnt  <= w_cnt_nxt;
      r_mask <= w_mask_nxt;
      // Results are published one cycle early so they are valid alongside done.
      if (r_pos == '0) begin
        r_done_id    <= r_id;
        r_match_cnt  <= w_cnt_nxt;
        r_match_mask <= w_mask_nxt;
      end
    end
  end

  patscan_core u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (w_start),
    .load_state (w_load_state),
    .valid      (r_state == SCAN),
    .in         (r_sh[WORD_W-1]),
    .match      (w_match),
    .state      (w_det_state)
  );

`ifdef PATSCAN_CONTEXT_EN
  logic [4:0] r_ctx [NREQ];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREQ; i++) r_ctx[i] <= S_R;
    else if (r_state == DONE) r_ctx[r_id] <= w_det_state;
  end
  assign w_load_state = r_ctx[w_gid];
`else
  logic w_unused_state;
  assign w_unused_state = ^w_det_state;
  assign w_load_state   = S_R;
`endif

  assign gnt        = w_start ? (NREQ'(1) << w_gid) : '0;
  assign busy       = (r_state != IDLE) || w_start;
  assign done       = (r_state == DONE);
  assign done_id    = r_done_id;
  assign match_cnt  = r_match_cnt;
  assign match_mask = r_match_mask;
endmodule
